// File: rtl/n1_core.sv
// n1_core: multi-cycle, single-issue, accumulator-style CPU with an on-chip
// 16-bit program/data RAM and a small general-purpose register file.
//
// Parameters
//   RAM_WORDS  RAM depth in 16-bit words (power of two, 2..256)
//   NUM_REGS   number of general-purpose registers r0..r(NUM_REGS-1) (1..8)
//
// Ports
//   clk         clock, all state changes on the rising edge
//   rst         synchronous active-high reset (RAM contents survive it)
//   prog_we     host RAM write strobe, honoured only in IDLE
//   prog_addr   host RAM address
//   prog_wdata  host RAM write data
//   prog_rdata  registered RAM[prog_addr], refreshed every IDLE cycle
//   run         start strobe (IDLE -> FETCH) / restart strobe (HALT -> IDLE)
//   out_data    low byte of the last OUT operand
//   out_valid   one-cycle pulse when out_data updates
//   halted      high while in HALT
//   busy        high while in FETCH or EXEC
//
// Optional feature
//   N1_BRANCH_EN  when defined, JMP (opcode 7) and JZ (opcode 8) are
//                 implemented; otherwise both decode as NOP.
module n1_core #(
  parameter int RAM_WORDS = 128,
  parameter int NUM_REGS  = 4,
  localparam int AW       = $clog2(RAM_WORDS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          prog_we,
  input  logic [AW-1:0] prog_addr,
  input  logic [15:0]   prog_wdata,
  output logic [15:0]   prog_rdata,
  input  logic          run,
  output logic [7:0]    out_data,
  output logic          out_valid,
  output logic          halted,
  output logic          busy
);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    EXEC,
    HALT
  } state_t;

  localparam logic [3:0] OP_MOVI  = 4'd1;
  localparam logic [3:0] OP_STORE = 4'd2;
  localparam logic [3:0] OP_LOAD  = 4'd3;
  localparam logic [3:0] OP_OUT   = 4'd4;
  localparam logic [3:0] OP_HALT  = 4'd5;
  localparam logic [3:0] OP_ADD   = 4'd6;

  logic [15:0]   ram [RAM_WORDS];
  // Eight physical slots so any 3-bit index is in range; slots at or above
  // NUM_REGS are never written and therefore always read back as zero.
  logic [15:0]   regs [8];

  state_t        state;
  logic [AW-1:0] pc;
  logic [15:0]   inst;

  logic [3:0]    opcode;
  logic [2:0]    rd_idx;
  logic [2:0]    rs_idx;
  logic [AW-1:0] addr;
  logic          rd_ok;
  logic [15:0]   rd_val;
  logic [15:0]   rs_val;
  logic [AW-1:0] next_pc;

  assign opcode = inst[15:12];
  assign rd_idx = inst[11:9];
  assign rs_idx = inst[8:6];
  assign addr   = inst[AW-1:0];
  assign rd_ok  = int'(rd_idx) < NUM_REGS;

  always_comb begin
    rd_val = '0;
    rs_val = '0;
    if (int'(rd_idx) < NUM_REGS) rd_val = regs[rd_idx];
    if (int'(rs_idx) < NUM_REGS) rs_val = regs[rs_idx];
  end

`ifdef N1_BRANCH_EN
  localparam logic [3:0] OP_JMP = 4'd7;
  localparam logic [3:0] OP_JZ  = 4'd8;

  logic take_branch;

  assign take_branch = (opcode == OP_JMP) || ((opcode == OP_JZ) && (rd_val == 16'd0));
  assign next_pc     = take_branch ? addr : pc + AW'(1);
`else
  assign next_pc = pc + AW'(1);
`endif

  // RAM write port. The FSM serialises host writes (IDLE only) and STORE
  // (EXEC only). A STORE whose EXEC edge coincides with rst is discarded.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == IDLE && prog_we) begin
        ram[prog_addr] <= prog_wdata;
      end else if (state == EXEC && opcode == OP_STORE) begin
        ram[addr] <= rd_val;
      end
    end
  end

  // Control FSM and datapath registers. HALT holds pc so the halt point is
  // stable; only the HALT -> IDLE restart rewinds pc to 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      pc         <= '0;
      inst       <= '0;
      out_data   <= '0;
      out_valid  <= 1'b0;
      halted     <= 1'b0;
      busy       <= 1'b0;
      prog_rdata <= '0;
      for (int i = 0; i < 8; i++) regs[i] <= '0;
    end else begin
      out_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          prog_rdata <= ram[prog_addr];
          if (run) begin
            state <= FETCH;
            busy  <= 1'b1;
          end
        end
        FETCH: begin
          inst  <= ram[pc];
          state <= EXEC;
        end
        EXEC: begin
          if (opcode == OP_HALT) begin
            state  <= HALT;
            busy   <= 1'b0;
            halted <= 1'b1;
          end else begin
            state <= FETCH;
            pc    <= next_pc;
          end
          case (opcode)
            OP_MOVI: if (rd_ok) regs[rd_idx] <= {8'h00, inst[7:0]};
            OP_LOAD: if (rd_ok) regs[rd_idx] <= ram[addr];
            OP_ADD:  if (rd_ok) regs[rd_idx] <= rd_val + rs_val;
            OP_OUT: begin
              out_data  <= ram[addr][7:0];
              out_valid <= 1'b1;
            end
            default: ;
          endcase
        end
        HALT: begin
          if (run) begin
            state  <= IDLE;
            pc     <= '0;
            halted <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_n1_core.sv
// tb_n1_core: self-checking bench for n1_core (RAM_WORDS=128, NUM_REGS=4).
// Directed scenarios plus random programs compared against an
// instruction-level interpreter kept in the bench.
module tb_n1_core;

  localparam int RW = 128;
  localparam int NR = 4;
  localparam int AW = 7;

  logic          clk = 1'b0;
  logic          rst;
  logic          prog_we;
  logic [AW-1:0] prog_addr;
  logic [15:0]   prog_wdata;
  logic [15:0]   prog_rdata;
  logic          run;
  logic [7:0]    out_data;
  logic          out_valid;
  logic          halted;
  logic          busy;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  n1_core #(.RAM_WORDS(RW), .NUM_REGS(NR)) dut (
    .clk(clk),
    .rst(rst),
    .prog_we(prog_we),
    .prog_addr(prog_addr),
    .prog_wdata(prog_wdata),
    .prog_rdata(prog_rdata),
    .run(run),
    .out_data(out_data),
    .out_valid(out_valid),
    .halted(halted),
    .busy(busy)
  );

  // Bench copy of the RAM image and the observation record of a run.
  logic [15:0] img [RW];
  int          d_edge[$];
  logic [7:0]  d_data[$];
  int          h_edge;

  // Reference interpreter state.
  logic [15:0] mm [RW];
  logic [15:0] mr [8];
  int          m_edge[$];
  logic [7:0]  m_data[$];
  bit          m_halted;
  int          m_count;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic load_word(input int a, input logic [15:0] d);
    prog_we    = 1'b1;
    prog_addr  = AW'(a);
    prog_wdata = d;
    tick();
    prog_we    = 1'b0;
  endtask

  task automatic load_image();
    for (int i = 0; i < RW; i++) load_word(i, img[i]);
  endtask

  task automatic read_word(input int a, output logic [15:0] d);
    prog_addr = AW'(a);
    tick();
    d = prog_rdata;
  endtask

  task automatic clear_image();
    for (int i = 0; i < RW; i++) img[i] = 16'h0000;
  endtask

  task automatic halt_to_idle();
    run = 1'b1;
    tick();
    run = 1'b0;
  endtask

  // Pulse run (edge 0) then record out_valid pulses and first halted edge.
  task automatic run_and_watch(input int edges, input bit hold_we);
    d_edge.delete();
    d_data.delete();
    h_edge = -1;
    run = 1'b1;
    tick();
    run = 1'b0;
    if (hold_we) begin
      prog_we    = 1'b1;
      prog_addr  = AW'(5);
      prog_wdata = 16'h5005;
    end
    for (int e = 1; e <= edges; e++) begin
      tick();
      if (out_valid === 1'b1) begin
        d_edge.push_back(e);
        d_data.push_back(out_data);
      end
      if (halted === 1'b1 && h_edge < 0) h_edge = e;
    end
    prog_we = 1'b0;
  endtask

  function automatic logic [15:0] rv(input logic [2:0] idx);
    return (int'(idx) < NR) ? mr[idx] : 16'h0000;
  endfunction

  // Executes img one instruction at a time; instruction n (1-based)
  // completes on DUT edge 2n after the run edge.
  task automatic model_run(input int limit);
    int pc;
    int nxt;
    int a;
    logic [15:0] w;
    logic [3:0] op;
    logic [2:0] rd;
    logic [2:0] rs;
    for (int i = 0; i < RW; i++) mm[i] = img[i];
    for (int i = 0; i < 8; i++) mr[i] = 16'h0000;
    m_edge.delete();
    m_data.delete();
    m_halted = 1'b0;
    m_count  = 0;
    pc       = 0;
    while (m_count < limit && !m_halted) begin
      w  = mm[pc];
      op = w[15:12];
      rd = w[11:9];
      rs = w[8:6];
      a  = int'(w[7:0]) % RW;
      m_count++;
      nxt = (pc + 1) % RW;
      case (op)
        4'd1: if (int'(rd) < NR) mr[rd] = {8'h00, w[7:0]};
        4'd2: mm[a] = rv(rd);
        4'd3: if (int'(rd) < NR) mr[rd] = mm[a];
        4'd4: begin
          m_edge.push_back(2 * m_count);
          m_data.push_back(mm[a][7:0]);
        end
        4'd5: m_halted = 1'b1;
        4'd6: if (int'(rd) < NR) mr[rd] = rv(rd) + rv(rs);
`ifdef N1_BRANCH_EN
        4'd7: nxt = a;
        4'd8: if (rv(rd) == 16'h0000) nxt = a;
`endif
        default: ;
      endcase
      pc = nxt;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; run = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_wdata = '0;
    tick();
    tick();
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (halted !== 1'b0) begin failures++; $display("[TB] FAIL reset_halted got=%b exp=0", halted); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (out_data !== 8'h00) begin failures++; $display("[TB] FAIL reset_out_data got=%h exp=00", out_data); end
    checks++; if (prog_rdata !== 16'h0000) begin failures++; $display("[TB] FAIL reset_prog_rdata got=%h exp=0000", prog_rdata); end
    rst = 1'b0;
  endtask

  task automatic test_example();
    clear_image();
    img[0] = 16'h1205; img[1] = 16'h2210; img[2] = 16'h4010; img[3] = 16'h5000;
    do_reset();
    load_image();
    run_and_watch(10, 1'b0);
    checks++; if (d_edge.size() !== 1) begin failures++; $display("[TB] FAIL example_pulses got=%0d exp=1", d_edge.size()); end
    checks++; if (d_edge[0] !== 6) begin failures++; $display("[TB] FAIL example_out_edge got=%0d exp=6", d_edge[0]); end
    checks++; if (d_data[0] !== 8'h05) begin failures++; $display("[TB] FAIL example_out_data got=%h exp=05", d_data[0]); end
    checks++; if (h_edge !== 8) begin failures++; $display("[TB] FAIL example_halt_edge got=%0d exp=8", h_edge); end
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL example_busy_in_halt got=%b exp=0", busy); end
  endtask

  task automatic test_host_rw();
    logic [15:0] d;
    do_reset();
    load_word(3, 16'h1111);
    tick();
    prog_we = 1'b1; prog_addr = AW'(3); prog_wdata = 16'hA5A5;
    tick();
    prog_we = 1'b0;
    checks++; if (prog_rdata !== 16'h1111) begin failures++; $display("[TB] FAIL host_rdata_same_edge got=%h exp=1111", prog_rdata); end
    tick();
    checks++; if (prog_rdata !== 16'hA5A5) begin failures++; $display("[TB] FAIL host_rdata_after_write got=%h exp=a5a5", prog_rdata); end
    // Write and run in the same IDLE cycle: the freshly written HALT at 0 runs.
    load_word(0, 16'h0000);
    load_word(1, 16'h5000);
    prog_we = 1'b1; prog_addr = AW'(0); prog_wdata = 16'h5000; run = 1'b1;
    tick();
    prog_we = 1'b0; run = 1'b0;
    checks++; if (busy !== 1'b1) begin failures++; $display("[TB] FAIL host_run_busy got=%b exp=1", busy); end
    h_edge = -1;
    for (int e = 1; e <= 6; e++) begin
      tick();
      if (halted === 1'b1 && h_edge < 0) h_edge = e;
    end
    checks++; if (h_edge !== 2) begin failures++; $display("[TB] FAIL host_run_we_halt_edge got=%0d exp=2", h_edge); end
    halt_to_idle();
    checks++; if (halted !== 1'b0) begin failures++; $display("[TB] FAIL halt_to_idle_halted got=%b exp=0", halted); end
    read_word(0, d);
    checks++; if (d !== 16'h5000) begin failures++; $display("[TB] FAIL host_run_we_ram got=%h exp=5000", d); end
  endtask

  task automatic test_add_wrap();
    logic [15:0] d;
    clear_image();
    img[0] = 16'h10FF;
    img[1] = 16'h12FF;
    for (int i = 2; i <= 10; i++) img[i] = 16'h6000;
    img[11] = 16'h6040;
    img[12] = 16'h2040;
    img[13] = 16'h4040;
    img[14] = 16'h5000;
    img[64] = 16'h1234;
    do_reset();
    load_image();
    run_and_watch(34, 1'b0);
    checks++; if (d_data.size() !== 1 || d_data[0] !== 8'hFF) begin failures++; $display("[TB] FAIL add_wrap_out got=%h exp=ff", d_data[0]); end
    checks++; if (h_edge !== 30) begin failures++; $display("[TB] FAIL add_wrap_halt_edge got=%0d exp=30", h_edge); end
    halt_to_idle();
    read_word(64, d);
    checks++; if (d !== 16'hFEFF) begin failures++; $display("[TB] FAIL add_wrap_ram got=%h exp=feff", d); end
  endtask

  task automatic test_branch();
    logic [7:0] exp_d;
    clear_image();
    img[0]    = 16'h8420;
    img[1]    = 16'h4030;
    img[2]    = 16'h5000;
    img[32]   = 16'h4031;
    img[33]   = 16'h5000;
    img[48]   = 16'h00AA;
    img[49]   = 16'h0055;
`ifdef N1_BRANCH_EN
    exp_d = 8'h55;
`else
    exp_d = 8'hAA;
`endif
    do_reset();
    load_image();
    run_and_watch(10, 1'b0);
    checks++; if (d_data.size() !== 1 || d_data[0] !== exp_d) begin failures++; $display("[TB] FAIL branch_out got=%h exp=%h", d_data[0], exp_d); end
    checks++; if (d_edge[0] !== 4) begin failures++; $display("[TB] FAIL branch_out_edge got=%0d exp=4", d_edge[0]); end
    checks++; if (h_edge !== 6) begin failures++; $display("[TB] FAIL branch_halt_edge got=%0d exp=6", h_edge); end
  endtask

  task automatic test_reset_mid();
    logic [15:0] d;
    clear_image();
    img[0]  = 16'h1207;
    img[1]  = 16'h2250;
    img[80] = 16'h1234;
    do_reset();
    load_image();
    run = 1'b1;
    tick();
    run = 1'b0;
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (busy !== 1'b0 || halted !== 1'b0) begin failures++; $display("[TB] FAIL midreset_idle got busy=%b halted=%b exp=0/0", busy, halted); end
    read_word(80, d);
    checks++; if (d !== 16'h1234) begin failures++; $display("[TB] FAIL midreset_store_dropped got=%h exp=1234", d); end
    load_word(0, 16'h2251);
    load_word(1, 16'h5000);
    load_word(81, 16'hFFFF);
    run_and_watch(6, 1'b0);
    halt_to_idle();
    read_word(81, d);
    checks++; if (d !== 16'h0000) begin failures++; $display("[TB] FAIL midreset_reg_cleared got=%h exp=0000", d); end
  endtask

  task automatic test_wrap();
    logic [15:0] d;
    clear_image();
    img[127] = 16'h407F;
    do_reset();
    load_image();
    run_and_watch(520, 1'b1);
    do_reset();
    checks++; if (d_edge.size() !== 2) begin failures++; $display("[TB] FAIL wrap_pulses got=%0d exp=2", d_edge.size()); end
    checks++; if (d_edge[0] !== 256 || d_edge[1] !== 512) begin failures++; $display("[TB] FAIL wrap_edges got=%0d,%0d exp=256,512", d_edge[0], d_edge[1]); end
    checks++; if (d_data[1] !== 8'h7F) begin failures++; $display("[TB] FAIL wrap_out got=%h exp=7f", d_data[1]); end
    read_word(5, d);
    checks++; if (d !== 16'h0000) begin failures++; $display("[TB] FAIL busy_write_ignored got=%h exp=0000", d); end
  endtask

  task automatic test_reg_oob();
    logic [15:0] d;
    clear_image();
    img[0]  = 16'h1A09;
    img[1]  = 16'h2A60;
    img[2]  = 16'h5000;
    img[96] = 16'hBEEF;
    do_reset();
    load_image();
    run_and_watch(8, 1'b0);
    checks++; if (h_edge !== 6) begin failures++; $display("[TB] FAIL oob_halt_edge got=%0d exp=6", h_edge); end
    halt_to_idle();
    read_word(96, d);
    checks++; if (d !== 16'h0000) begin failures++; $display("[TB] FAIL oob_store got=%h exp=0000", d); end
  endtask

  task automatic test_random();
    logic [15:0] d;
    int op;
    int imm;
    int n;
    for (int it = 0; it < 8; it++) begin
      for (int i = 0; i < 31; i++) begin
        op = $urandom_range(0, 15);
        if (op == 2 || op == 3 || op == 4) imm = 64 + $urandom_range(0, 63);
        else if (op == 7 || op == 8) imm = $urandom_range(0, 31);
        else imm = $urandom_range(0, 255);
        img[i] = {4'(op), 3'($urandom_range(0, 7)), 1'b0, 8'(imm)};
        if (op == 6) img[i][8:6] = 3'($urandom_range(0, 7));
      end
      img[31] = 16'h5000;
      for (int i = 32; i < RW; i++) img[i] = 16'($urandom());
      model_run(120);
      n = m_count;
      do_reset();
      load_image();
      run_and_watch(2 * n, 1'b0);
      checks++; if (d_edge.size() !== m_edge.size()) begin failures++; $display("[TB] FAIL rand%0d_out_count got=%0d exp=%0d", it, d_edge.size(), m_edge.size()); end
      for (int k = 0; k < m_edge.size() && k < d_edge.size(); k++) begin
        checks++; if (d_edge[k] !== m_edge[k] || d_data[k] !== m_data[k]) begin failures++; $display("[TB] FAIL rand%0d_out%0d got=%h@%0d exp=%h@%0d", it, k, d_data[k], d_edge[k], m_data[k], m_edge[k]); end
      end
      checks++; if (halted !== m_halted) begin failures++; $display("[TB] FAIL rand%0d_halted got=%b exp=%b", it, halted, m_halted); end
      if (m_halted) halt_to_idle();
      else do_reset();
      for (int a = 64; a < RW; a++) begin
        read_word(a, d);
        checks++; if (d !== mm[a]) begin failures++; $display("[TB] FAIL rand%0d_ram[%0d] got=%h exp=%h", it, a, d, mm[a]); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_example();
    test_host_rw();
    test_add_wrap();
    test_branch();
    test_reset_mid();
    test_wrap();
    test_reg_oob();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
